// File: rtl/usb_fifo_bridge_pkg.sv
// Shared types and constants for the FT245 USB FIFO bridge and its consumers.
package usb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_LOW,
    RX_GAP,
    MEM_RD,
    TX_WAIT,
    TX_WRH,
    TX_WRL
  } state_e;

  typedef enum logic [1:0] {
    BK_LO,
    BK_HI,
    BK_CSUM
  } byte_kind_e;

  localparam int DEF_RD_LOW   = 5;
  localparam int DEF_RD_GAP   = 2;
  localparam int DEF_MEM_WAIT = 2;
  localparam int DEF_WR_HIGH  = 4;
  localparam int DEF_WR_LOW   = 6;
  localparam int DEF_AW       = 20;
  localparam int TMR_W        = 8;

  // Command byte values decoded by the measurement controller.
  localparam logic [7:0] CMD_01 = 8'h01;
  localparam logic [7:0] CMD_02 = 8'h02;
  localparam logic [7:0] CMD_03 = 8'h03;
  localparam logic [7:0] CMD_04 = 8'h04;
  localparam logic [7:0] CMD_05 = 8'h05;
  localparam logic [7:0] CMD_06 = 8'h06;
  localparam logic [7:0] CMD_07 = 8'h07;
  localparam logic [7:0] CMD_08 = 8'h08;
  localparam logic [7:0] CMD_16 = 8'h10;
  localparam logic [7:0] CMD_17 = 8'h11;
  localparam logic [7:0] CMD_18 = 8'h12;
  localparam logic [7:0] CMD_19 = 8'h13;

  function automatic logic [7:0] even_len(input logic [7:0] len);
    return len & 8'hFE;
  endfunction

endpackage

// File: rtl/usb_fifo_bridge_strobe_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module usb_strobe_timer
  import usb_bridge_pkg::*;
#(
  parameter int CNT_W = TMR_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/usb_fifo_bridge.sv
// FT245 USB FIFO engine: command byte reception and SRAM burst streaming.
// Define USB_CHECKSUM_EN to append an XOR checksum byte to every burst.
module usb_fifo_bridge
  import usb_bridge_pkg::*;
#(
  parameter int RD_LOW   = DEF_RD_LOW,
  parameter int RD_GAP   = DEF_RD_GAP,
  parameter int MEM_WAIT = DEF_MEM_WAIT,
  parameter int WR_HIGH  = DEF_WR_HIGH,
  parameter int WR_LOW   = DEF_WR_LOW,
  parameter int AW       = DEF_AW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RXF,
  input  logic          TXE,
  output logic          RD,
  output logic          WR,
  input  logic [7:0]    USBX_I,
  output logic [7:0]    USBX_O,
  output logic          USBX_OE,
  output logic          CMD_VALID,
  output logic [7:0]    CMD_BYTE,
  input  logic          TX_START,
  input  logic [AW-1:0] TX_BASE,
  input  logic [7:0]    TX_LEN,
  output logic [AW-1:0] MEM_ADRS,
  output logic          MEM_OE,
  input  logic [15:0]   MEM_DATA,
  output logic          BUSY,
  output logic          TX_DONE
);

`ifdef USB_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_e     state, state_nxt;
  byte_kind_e kind;

  logic             pending;
  logic [AW-1:0]    lat_base, addr, mem_adrs;
  logic [7:0]       lat_len, rem;
  logic             mem_ph;
  logic [7:0]       tx_byte, word_hi, csum, cmd_byte;
  logic             csum_sent, csum_due, oe_q, cmd_valid;
  logic             burst_end, tx_done;
  logic             tmr_load, tmr_tc;
  logic [TMR_W-1:0] tmr_val;

  usb_strobe_timer #(.CNT_W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign csum_due  = CSUM_EN && !csum_sent;
  assign burst_end = (state == MEM_RD) && !mem_ph && (rem == '0);
  assign tx_done   = burst_end && !csum_due;

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state)
      IDLE: begin
        if (!RXF) begin
          state_nxt = RX_LOW;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(RD_LOW - 1);
        end else if (pending) begin
          state_nxt = MEM_RD;
        end
      end
      RX_LOW: begin
        if (tmr_tc) begin
          state_nxt = RX_GAP;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(RD_GAP - 1);
        end
      end
      RX_GAP: begin
        if (tmr_tc) state_nxt = IDLE;
      end
      MEM_RD: begin
        // First cycle decides: finish, send checksum, or start an SRAM read.
        if (!mem_ph) begin
          if (rem == '0) begin
            state_nxt = csum_due ? TX_WAIT : IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(MEM_WAIT - 1);
          end
        end else if (tmr_tc) begin
          state_nxt = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!TXE) begin
          state_nxt = TX_WRH;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(WR_HIGH - 1);
        end
      end
      TX_WRH: begin
        if (tmr_tc) begin
          state_nxt = TX_WRL;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(WR_LOW - 1);
        end
      end
      TX_WRL: begin
        if (tmr_tc) state_nxt = (kind == BK_LO) ? TX_WAIT : MEM_RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      pending   <= 1'b0;
      mem_ph    <= 1'b0;
      mem_adrs  <= '0;
      tx_byte   <= '0;
      kind      <= BK_LO;
      csum_sent <= 1'b0;
      oe_q      <= 1'b0;
      cmd_byte  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_valid <= 1'b0;
      if (TX_START && !pending) pending <= 1'b1;
      unique case (state)
        IDLE: begin
          if (RXF && pending) begin
            pending   <= 1'b0;
            csum_sent <= 1'b0;
          end
        end
        RX_LOW: begin
          if (tmr_tc) begin
            cmd_byte  <= USBX_I;
            cmd_valid <= 1'b1;
          end
        end
        MEM_RD: begin
          if (!mem_ph) begin
            if (rem == '0) begin
              oe_q <= csum_due;
              if (csum_due) begin
                tx_byte   <= csum;
                kind      <= BK_CSUM;
                csum_sent <= 1'b1;
              end
            end else begin
              mem_adrs <= addr;
              mem_ph   <= 1'b1;
            end
          end else if (tmr_tc) begin
            mem_ph  <= 1'b0;
            tx_byte <= MEM_DATA[7:0];
            kind    <= BK_LO;
            oe_q    <= 1'b1;
          end
        end
        TX_WRL: begin
          if (tmr_tc && kind == BK_LO) begin
            tx_byte <= word_hi;
            kind    <= BK_HI;
          end
        end
        default: ;
      endcase
    end
  end

  // Burst datapath registers carry no reset; each is loaded before use.
  always_ff @(posedge CLK) begin
    if (TX_START && !pending) begin
      lat_base <= TX_BASE;
      lat_len  <= even_len(TX_LEN);
    end
    unique case (state)
      IDLE: begin
        if (RXF && pending) begin
          addr <= lat_base;
          rem  <= lat_len;
          csum <= '0;
        end
      end
      MEM_RD: begin
        if (mem_ph && tmr_tc) begin
          word_hi <= MEM_DATA[15:8];
          csum    <= csum ^ MEM_DATA[7:0] ^ MEM_DATA[15:8];
        end
      end
      TX_WRL: begin
        if (tmr_tc && kind == BK_HI) begin
          addr <= addr + AW'(1);
          rem  <= rem - 8'd2;
        end
      end
      default: ;
    endcase
  end

  assign RD        = (state != RX_LOW);
  assign WR        = (state == TX_WRH);
  assign USBX_O    = tx_byte;
  assign USBX_OE   = oe_q && !tx_done;
  assign CMD_VALID = cmd_valid;
  assign CMD_BYTE  = cmd_byte;
  assign MEM_ADRS  = mem_adrs;
  assign MEM_OE    = (state == MEM_RD) && mem_ph;
  assign BUSY      = (state != IDLE) || pending;
  assign TX_DONE   = tx_done;

endmodule

// File: tb/tb_usb_fifo_bridge.sv
// Directed self-checking bench for usb_fifo_bridge.
module tb_usb_fifo_bridge;

  localparam int AW = 20;
`ifdef USB_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RXF = 1'b1;
  logic          TXE = 1'b1;
  logic          RD, WR;
  logic [7:0]    USBX_I = 8'h00;
  logic [7:0]    USBX_O;
  logic          USBX_OE, CMD_VALID;
  logic [7:0]    CMD_BYTE;
  logic          TX_START = 1'b0;
  logic [AW-1:0] TX_BASE = '0;
  logic [7:0]    TX_LEN = 8'h00;
  logic [AW-1:0] MEM_ADRS;
  logic          MEM_OE;
  logic [15:0]   MEM_DATA;
  logic          BUSY, TX_DONE;

  usb_fifo_bridge dut (
    .CLK(CLK), .RST(RST), .RXF(RXF), .TXE(TXE), .RD(RD), .WR(WR),
    .USBX_I(USBX_I), .USBX_O(USBX_O), .USBX_OE(USBX_OE),
    .CMD_VALID(CMD_VALID), .CMD_BYTE(CMD_BYTE),
    .TX_START(TX_START), .TX_BASE(TX_BASE), .TX_LEN(TX_LEN),
    .MEM_ADRS(MEM_ADRS), .MEM_OE(MEM_OE), .MEM_DATA(MEM_DATA),
    .BUSY(BUSY), .TX_DONE(TX_DONE)
  );

  always #4 CLK = ~CLK;

  always_comb begin
    case (MEM_ADRS)
      20'h00010: MEM_DATA = 16'hA1B2;
      20'h00011: MEM_DATA = 16'hC3D4;
      20'hFFFFF: MEM_DATA = 16'h1122;
      20'h00000: MEM_DATA = 16'h3344;
      default:   MEM_DATA = 16'hDEAD;
    endcase
  end

  // Observers: bytes latched on WR falling edges, pulse counts, RD timing.
  logic [7:0] blog [0:127];
  int nbytes = 0, ndone = 0, ncmd = 0, oe_bad = 0;
  int rd_lo_run = 0, rd_hi_run = 0, lo_min = 1000, lo_max = 0, gap_min = 1000;
  bit seen_read = 0;
  logic wr_q = 1'b0;

  always @(negedge CLK) begin
    if (wr_q && !WR) begin
      if (nbytes < 128) blog[nbytes] = USBX_O;
      nbytes++;
      if (!USBX_OE) oe_bad++;
    end
    wr_q = WR;
    if (TX_DONE) ndone++;
    if (CMD_VALID) ncmd++;
    if (!RD) begin
      if (seen_read && rd_lo_run == 0 && rd_hi_run < gap_min) gap_min = rd_hi_run;
      rd_hi_run = 0;
      rd_lo_run++;
    end else begin
      if (rd_lo_run != 0) begin
        if (rd_lo_run < lo_min) lo_min = rd_lo_run;
        if (rd_lo_run > lo_max) lo_max = rd_lo_run;
        seen_read = 1;
      end
      rd_lo_run = 0;
      rd_hi_run++;
    end
  end

  int errors = 0, checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start_burst(input logic [AW-1:0] base, input logic [7:0] len);
    TX_BASE  = base;
    TX_LEN   = len;
    TX_START = 1'b1;
    @(negedge CLK);
    TX_START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    while (!seen && lat < budget) begin
      @(negedge CLK);
      lat++;
      if (TX_DONE) seen = 1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_cmd(input string tag, input int budget);
    bit seen;
    int n;
    seen = 0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge CLK);
      n++;
      if (CMD_VALID) seen = 1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0, c0, lat, bad, oe0, k;

    cyc(3);
    check_eq("rst_RD", RD, 1);
    check_eq("rst_WR", WR, 0);
    check_eq("rst_USBX_OE", USBX_OE, 0);
    check_eq("rst_USBX_O", USBX_O, 0);
    check_eq("rst_CMD_VALID", CMD_VALID, 0);
    check_eq("rst_CMD_BYTE", CMD_BYTE, 0);
    check_eq("rst_MEM_ADRS", MEM_ADRS, 0);
    check_eq("rst_MEM_OE", MEM_OE, 0);
    check_eq("rst_BUSY", BUSY, 0);
    check_eq("rst_TX_DONE", TX_DONE, 0);
    RST = 1'b0;
    cyc(2);

    // Two back-to-back command reads with RXF held low.
    USBX_I = 8'h07;
    RXF    = 1'b0;
    wait_cmd("cmd1_seen", 40);
    check_eq("cmd1_byte", CMD_BYTE, 8'h07);
    USBX_I = 8'h5A;
    wait_cmd("cmd2_seen", 40);
    RXF = 1'b1;
    check_eq("cmd2_byte", CMD_BYTE, 8'h5A);
    cyc(10);
    check_eq("cmd_valid_pulses", ncmd, 2);
    check_eq("rd_low_min", lo_min, 5);
    check_eq("rd_low_max", lo_max, 5);
    check_eq("rd_gap_ge2", 32'(gap_min >= 2), 1);
    check_eq("cmd_hold", CMD_BYTE, 8'h5A);

    // Plain burst, TXE always low.
    TXE = 1'b0;
    n0 = nbytes; d0 = ndone;
    start_burst(20'h00010, 8'd4);
    wait_done("b1_done", 200, lat);
    check_eq("b1_latency", lat, 51 + 12 * CS);
    cyc(3);
    check_eq("b1_nbytes", nbytes - n0, 4 + CS);
    check_eq("b1_byte0", blog[n0],     8'hB2);
    check_eq("b1_byte1", blog[n0 + 1], 8'hA1);
    check_eq("b1_byte2", blog[n0 + 2], 8'hD4);
    check_eq("b1_byte3", blog[n0 + 3], 8'hC3);
`ifdef USB_CHECKSUM_EN
    check_eq("b1_csum", blog[n0 + 4], 8'h04);
`endif
    check_eq("b1_done_pulses", ndone - d0, 1);
    check_eq("b1_mem_adrs", MEM_ADRS, 20'h00011);
    check_eq("b1_busy", BUSY, 0);
    check_eq("b1_oe_off", USBX_OE, 0);

    // Same burst with a 50-cycle TXE stall before the high byte.
    n0 = nbytes; d0 = ndone;
    start_burst(20'h00010, 8'd4);
    k = 0;
    while (nbytes == n0 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check_eq("b2_first_byte", 32'(nbytes > n0), 1);
    TXE = 1'b1;
    cyc(8);
    bad = 0;
    repeat (50) begin
      @(negedge CLK);
      if (WR || USBX_O != 8'hA1 || !USBX_OE) bad++;
    end
    check_eq("b2_stall_hold", bad, 0);
    check_eq("b2_stall_nbytes", nbytes - n0, 1);
    TXE = 1'b0;
    wait_done("b2_done", 200, lat);
    cyc(3);
    check_eq("b2_nbytes", nbytes - n0, 4 + CS);
    check_eq("b2_byte1", blog[n0 + 1], 8'hA1);
    check_eq("b2_byte2", blog[n0 + 2], 8'hD4);
    check_eq("b2_byte3", blog[n0 + 3], 8'hC3);
    check_eq("b2_done_pulses", ndone - d0, 1);

    // Command and burst request arrive together; odd length 1 means empty burst.
    n0 = nbytes; d0 = ndone; c0 = ncmd;
    USBX_I = 8'h3C;
    RXF    = 1'b0;
    start_burst(20'h00010, 8'd1);
    wait_cmd("t4_cmd_first", 40);
    RXF = 1'b1;
    check_eq("t4_cmd_byte", CMD_BYTE, 8'h3C);
    check_eq("t4_busy_pending", BUSY, 1);
    check_eq("t4_no_done_yet", ndone - d0, 0);
    wait_done("t4_done", 100, lat);
    cyc(3);
    check_eq("t4_nbytes", nbytes - n0, CS);
`ifdef USB_CHECKSUM_EN
    check_eq("t4_csum_zero", blog[n0], 8'h00);
`endif
    check_eq("t4_done_pulses", ndone - d0, 1);
    check_eq("t4_cmd_pulses", ncmd - c0, 1);

    // Address wrap at the top of SRAM.
    n0 = nbytes; d0 = ndone;
    start_burst(20'hFFFFF, 8'd4);
    wait_done("b5_done", 200, lat);
    cyc(3);
    check_eq("b5_nbytes", nbytes - n0, 4 + CS);
    check_eq("b5_byte0", blog[n0],     8'h22);
    check_eq("b5_byte1", blog[n0 + 1], 8'h11);
    check_eq("b5_byte2", blog[n0 + 2], 8'h44);
    check_eq("b5_byte3", blog[n0 + 3], 8'h33);
`ifdef USB_CHECKSUM_EN
    check_eq("b5_csum", blog[n0 + 4], 8'h44);
`endif
    check_eq("b5_mem_adrs", MEM_ADRS, 20'h00000);
    check_eq("oe_at_wr_fall", oe_bad, 0);
    oe0 = oe_bad;

    // Reset during the WR-high phase of the first byte.
    d0 = ndone;
    start_burst(20'h00010, 8'd4);
    cyc(7);
    check_eq("r6_wr_high", WR, 1);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("r6_wr_low", WR, 0);
    check_eq("r6_busy", BUSY, 0);
    check_eq("r6_oe", USBX_OE, 0);
    check_eq("r6_mem_adrs", MEM_ADRS, 0);
    RST = 1'b0;
    cyc(60);
    check_eq("r6_no_done", ndone - d0, 0);
    check_eq("r6_idle", BUSY, 0);
    check_eq("r6_wr_idle", WR, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_fifo_bridge.md
Name: usb_fifo_bridge

Overview:
- FT245-style USB FIFO engine downstream of the pulse-height/waveform SRAM recorder.
- Receives single command bytes from the PC when RXF is low.
- Streams recorded SRAM contents to the PC on request: 16-bit words are read from SRAM and sent low byte first, then high byte, with TXE flow control.
- Replaces the inline RD/WR sequencing previously embedded in the measurement controller.

Parameters:
- RD_LOW, 5: cycles RD is held low before USBX is sampled.
- RD_GAP, 2: cycles RD is held high after a read, before RXF is re-examined.
- MEM_WAIT, 2: cycles from address/MEM_OE valid to MEM_DATA capture.
- WR_HIGH, 4: cycles WR is held high with data valid.
- WR_LOW, 6: cycles WR is held low after the falling edge (data still driven).
- AW, 20: SRAM address width.

Ports:
- CLK  in  1  system clock, 125 MHz
- RST  in  1  synchronous, active-high reset
- RXF  in  1  low = PC->device byte available
- TXE  in  1  low = device->PC FIFO has space
- RD  out  1  FT245 read strobe, active low
- WR  out  1  FT245 write strobe; byte latched on falling edge
- USBX_I  in  8  USB data bus input
- USBX_O  out  8  USB data bus output
- USBX_OE  out  1  drive enable for USBX (top level builds the tristate)
- CMD_VALID  out  1  one-cycle pulse, new command byte
- CMD_BYTE  out  8  last received command; held until the next command
- TX_START  in  1  one-cycle request to start a burst
- TX_BASE  in  AW  first SRAM word address
- TX_LEN  in  8  burst length in bytes; bit0 ignored (128 typical)
- MEM_ADRS  out  AW  SRAM address
- MEM_OE  out  1  SRAM output enable request, active high
- MEM_DATA  in  16  SRAM read data
- BUSY  out  1  high in any non-IDLE state or while a request is pending
- TX_DONE  out  1  one-cycle pulse at burst end

Behaviour:
- Reset values: RD=1, WR=0, USBX_OE=0, USBX_O=0, CMD_VALID=0, CMD_BYTE=0, MEM_ADRS=0, MEM_OE=0, BUSY=0, TX_DONE=0, pending=0, state=IDLE.
- TX_START when pending=0: latch TX_BASE, TX_LEN&~1 and set pending, in any state. TX_START when pending=1 is ignored.
- IDLE priority: RXF low beats pending.
  - RXF low -> RX_LOW.
  - Else if pending -> MEM_RD.
- RX_LOW:
  - RD=0 for RD_LOW cycles.
  - On the last cycle: capture USBX_I into CMD_BYTE, pulse CMD_VALID, set RD=1 -> RX_GAP.
- RX_GAP: wait RD_GAP cycles -> IDLE. RXF is not sampled during RX_LOW or RX_GAP.
- MEM_RD:
  - Clear pending on entry.
  - If remaining length = 0: pulse TX_DONE -> IDLE. No WR edge occurs.
  - Else: MEM_ADRS = word address, MEM_OE=1 for MEM_WAIT cycles, capture MEM_DATA, MEM_OE=0 -> TX_WAIT (low byte).
- TX_WAIT:
  - USBX_O = current byte, USBX_OE=1, WR=0.
  - Wait while TXE=1; data and WR are held stable.
  - TXE=0 -> TX_WRH.
- TX_WRH: WR=1 for WR_HIGH cycles -> TX_WRL.
- TX_WRL:
  - WR=0 for WR_LOW cycles; USBX_OE stays 1 throughout.
  - If the low byte was just sent: -> TX_WAIT (high byte).
  - If the high byte was just sent: address+1 (wraps modulo 2^AW), remaining-2 -> MEM_RD.
- End of burst: TX_DONE pulses in the cycle MEM_RD sees remaining=0; USBX_OE=0 from that cycle.
- Byte latency per word with TXE held low: MEM_WAIT + 2×(1+WR_HIGH+WR_LOW) cycles plus the MEM_RD entry cycle.
- RXF low during a burst is ignored until IDLE.
- RST mid-operation:
  - Immediate return to reset values. A partially sent word is dropped; the pending request is cleared.
  - WR=1 at reset assertion is forced low, which produces a falling edge; the bench must tolerate one spurious byte in this case.

Optional Feature:
- USB_CHECKSUM_EN defined: after the last data byte, one extra byte is sent through TX_WAIT/TX_WRH/TX_WRL.
  - Its value is the XOR of all data bytes in the burst.
  - TX_DONE pulses after this byte.
  - With TX_LEN=0, the checksum byte 0x00 is still sent.
- Not defined: no extra byte; behaviour exactly as above.

Decomposition:
- Package usb_bridge_pkg holds:
  - state enum (IDLE, RX_LOW, RX_GAP, MEM_RD, TX_WAIT, TX_WRH, TX_WRL);
  - default timing constants;
  - command codes 1-8 and 16-19 as named constants for the consumer.
- One sub-module is natural: usb_strobe_timer, a loadable down-counter with a terminal-count flag, shared by all timed states.

Test Plan:
- RXF low, USBX_I=0x07 -> RD low for exactly 5 cycles, CMD_BYTE=0x07, one CMD_VALID pulse, RD high at least 2 cycles before the next read.
- TX_START with TX_BASE=0x00010, TX_LEN=4, SRAM[0x10]=0xA1B2, SRAM[0x11]=0xC3D4, TXE=0 -> 4 WR falling edges carrying B2,A1,D4,C3 in that order; TX_DONE pulses once; MEM_ADRS ends at 0x00011.
- Same burst with TXE=1 for 50 cycles before the second byte -> WR stays 0, USBX_O holds A1 throughout the stall; the sequence completes unchanged after TXE drops.
- TX_START and RXF low in the same IDLE cycle -> command read completes first, then the burst runs; TX_LEN=0 -> TX_DONE with zero WR edges.
- TX_BASE=0xFFFFF, TX_LEN=4 -> second word read from address 0x00000.
- USB_CHECKSUM_EN defined, data B2,A1,D4,C3 -> fifth byte 0x04 is sent, then TX_DONE.
